// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register.
//   stage_state_e : per-stage fill state (EMPTY / ONE / TWO)
//   occ_width()   : width of a 0..2*depth occupancy count
//   DX_*_W        : decode->execute bundle widths
package pipe_pkg;

   // The encoding equals the number of held entries, which the slot relies on.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_e;

   localparam int unsigned DX_DATA_W = 128;
   localparam int unsigned DX_CTRL_W = 24;

   function automatic int unsigned occ_width(input int unsigned depth);
      return $clog2(2 * depth + 1);
   endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One elastic stage: main register plus skid register.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 synchronous discard of held entries
//   in_valid/in_ready     upstream handshake (in_ready registered)
//   in_payload            entry from upstream
//   out_valid/out_ready   downstream handshake (out_valid registered)
//   out_payload           main register contents
//   occ                   held entries, 0..2 (registered)
module pipe_skid_slot
   import pipe_pkg::*;
#(
   parameter int unsigned W = DX_DATA_W + DX_CTRL_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_payload,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_payload,
   output logic [1:0]   occ
);

   stage_state_e state_q, state_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         in_fire;
   logic         out_fire;

   // Next-state and datapath selection.
   always_comb begin
      state_d  = state_q;
      main_d   = main_q;
      skid_d   = skid_q;
      in_fire  = in_valid & in_ready;
      out_fire = out_valid & out_ready;

      unique case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               main_d  = in_payload;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_fire && out_fire) begin
               main_d = in_payload;
            end else if (in_fire) begin
               skid_d  = in_payload;
               state_d = ST_TWO;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (out_fire) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      // Flush wins over any transfer; registers keep stale contents.
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = main_q;
         skid_d  = skid_q;
      end
   end

   // State and registered handshake/occupancy outputs, all from state_d.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_EMPTY;
         main_q    <= '0;
         skid_q    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         occ       <= 2'd0;
      end else begin
         state_q   <= state_d;
         main_q    <= main_d;
         skid_q    <= skid_d;
         in_ready  <= (state_d != ST_TWO);
         out_valid <= (state_d != ST_EMPTY);
         occ       <= 2'(state_d);
      end
   end

   assign out_payload = main_q;

endmodule

// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline register: DEPTH cascaded skid slots carrying data + ctrl.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   flush                   synchronous discard of every held entry
//   in_valid/in_ready       upstream handshake (in_ready registered)
//   in_data/in_ctrl         payload and control bundle in
//   out_valid/out_ready     downstream handshake
//   out_data/out_ctrl       payload and control bundle out (ctrl zeroed on bubble)
//   occupancy               total held entries, 0..2*DEPTH
module pipe_elastic_stage
   import pipe_pkg::*;
#(
   parameter  int unsigned DATA_W          = DX_DATA_W,
   parameter  int unsigned CTRL_W          = DX_CTRL_W,
   parameter  int unsigned DEPTH           = 1,
   parameter  int unsigned CLEAR_ON_BUBBLE = 1,
   localparam int unsigned OCC_W           = occ_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [OCC_W-1:0]  occupancy
);

   localparam int unsigned PW = DATA_W + CTRL_W;

   logic [DEPTH:0] vld;
   logic [DEPTH:0] rdy;
   logic [PW-1:0]  pay      [DEPTH+1];
   logic [1:0]     slot_occ [DEPTH];

   assign vld[0]     = in_valid;
   assign pay[0]     = {in_data, in_ctrl};
   assign rdy[DEPTH] = out_ready;
   assign in_ready   = rdy[0];

   // Slot k reads interface k and drives interface k+1.
   for (genvar k = 0; k < DEPTH; k++) begin : g_slot
      pipe_skid_slot #(.W(PW)) u_slot (
         .clk         (clk),
         .rst_n       (rst_n),
         .flush       (flush),
         .in_valid    (vld[k]),
         .in_ready    (rdy[k]),
         .in_payload  (pay[k]),
         .out_valid   (vld[k+1]),
         .out_ready   (rdy[k+1]),
         .out_payload (pay[k+1]),
         .occ         (slot_occ[k])
      );
   end

   // Total occupancy, a sum of registered per-slot counts.
   always_comb begin
      occupancy = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         occupancy = occupancy + OCC_W'(slot_occ[k]);
      end
   end

   assign out_valid = vld[DEPTH];
   assign out_data  = pay[DEPTH][PW-1:CTRL_W];

   // Bubble clear keeps stale control bits from looking like a live op.
   if (CLEAR_ON_BUBBLE != 0) begin : g_clr
      assign out_ctrl = vld[DEPTH] ? pay[DEPTH][CTRL_W-1:0] : '0;
   end else begin : g_raw
      assign out_ctrl = pay[DEPTH][CTRL_W-1:0];
   end

endmodule
